// File: rtl/bb_seq_controller_pkg.sv
// Shared types and constants for the BitBlaster sequential controller.
package bitblaster_pkg;

    // Register-class opcodes (cls = 00), op = IR[3:0]
    typedef enum logic [3:0] {
        LOAD = 4'b0000,
        COPY = 4'b0001,
        ADD  = 4'b0010,
        SUB  = 4'b0011,
        AND  = 4'b0100,
        OR   = 4'b0101,
        XOR  = 4'b0110,
        INV  = 4'b0111,
        FLP  = 4'b1000,
        SHL  = 4'b1001,
        SHR  = 4'b1010,
        ASR  = 4'b1011
    } opcode_t;

    // Instruction class, IR[DATA_W-1:DATA_W-2]
    typedef enum logic [1:0] {
        CLS_REG  = 2'b00,
        CLS_ILL  = 2'b01,
        CLS_ADDI = 2'b10,
        CLS_SUBI = 2'b11
    } cls_t;

    // Timestep FSM: fetch, decode, execute, write-back
    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;

endpackage

// File: rtl/bb_seq_controller_if.sv
// Controller <-> datapath signal bundle: bus capture inputs and all control strobes.
interface bb_seq_controller_if #(
    parameter int unsigned DATA_W = 10
);
    logic [DATA_W-1:0] bus_in;
    logic              ext_valid;
    logic [DATA_W-1:0] IMM;
    logic              imm_oe;
    logic [1:0]        Rin;
    logic [1:0]        Rout;
    logic              ENW;
    logic              ENR;
    logic              Ain;
    logic              Gin;
    logic              Gout;
    logic [3:0]        ALUcont;
    logic              Ext;
    logic              IRin;
    logic              done;
    logic              illegal;
    logic [1:0]        tstep;

    // Controller side
    modport master (
        input  bus_in, ext_valid,
        output IMM, imm_oe, Rin, Rout, ENW, ENR, Ain, Gin, Gout,
               ALUcont, Ext, IRin, done, illegal, tstep
    );

    // Datapath side
    modport slave (
        output bus_in, ext_valid,
        input  IMM, imm_oe, Rin, Rout, ENW, ENR, Ain, Gin, Gout,
               ALUcont, Ext, IRin, done, illegal, tstep
    );
endinterface

// File: rtl/bb_instr_decode.sv
// Combinational instruction field decode and immediate extension.
module bb_instr_decode
    import bitblaster_pkg::*;
#(
    parameter int unsigned DATA_W     = 10,
    parameter bit          IMM_SIGNED = 1'b0
) (
    input  logic [DATA_W-1:0] ir,
    output cls_t              cls,
    output logic [1:0]        rx,
    output logic [1:0]        ry,
    output logic [3:0]        op,
    output logic [DATA_W-1:0] imm_ext,
    output logic              is_load,
    output logic              is_copy,
    output logic              is_alu,
    output logic              is_imm,
    output logic              is_illegal
);
    localparam int unsigned IMM_W = DATA_W - 4;

    logic is_reg;

    // Field extraction and instruction classification
    always_comb begin
        cls        = cls_t'(ir[DATA_W-1 -: 2]);
        rx         = ir[DATA_W-3 -: 2];
        ry         = ir[DATA_W-5 -: 2];
        op         = ir[3:0];
        is_reg     = (cls == CLS_REG);
        is_load    = is_reg && (op == LOAD);
        is_copy    = is_reg && (op == COPY);
        is_alu     = is_reg && (op >= ADD) && (op <= ASR);
        is_imm     = (cls == CLS_ADDI) || (cls == CLS_SUBI);
        is_illegal = (cls == CLS_ILL) || (is_reg && (op > ASR));
        if (IMM_SIGNED)
            imm_ext = {{4{ir[IMM_W-1]}}, ir[IMM_W-1:0]};
        else
            imm_ext = {4'b0000, ir[IMM_W-1:0]};
    end
endmodule

// File: rtl/bb_seq_controller.sv
// BitBlaster sequential controller: IR, timestep FSM and datapath control decode.
module bb_seq_controller
    import bitblaster_pkg::*;
#(
    parameter int unsigned DATA_W        = 10,
    parameter bit          IMM_SIGNED    = 1'b0,
    parameter bit          EXT_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    bb_seq_controller_if.master  bus
);
    state_t            state, state_n;
    logic [DATA_W-1:0] ir;
    logic              ir_load;
    logic              ext_ok;

    cls_t              cls;
    logic [1:0]        rx, ry;
    logic [3:0]        op;
    logic [DATA_W-1:0] imm_ext;
    logic              is_load, is_copy, is_alu, is_imm, is_illegal;

    assign ext_ok = EXT_HANDSHAKE ? bus.ext_valid : 1'b1;

    bb_instr_decode #(
        .DATA_W     (DATA_W),
        .IMM_SIGNED (IMM_SIGNED)
    ) u_decode (
        .ir         (ir),
        .cls        (cls),
        .rx         (rx),
        .ry         (ry),
        .op         (op),
        .imm_ext    (imm_ext),
        .is_load    (is_load),
        .is_copy    (is_copy),
        .is_alu     (is_alu),
        .is_imm     (is_imm),
        .is_illegal (is_illegal)
    );

    // State register and instruction register capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= T0;
            ir    <= '0;
        end else begin
            state <= state_n;
            if (ir_load)
                ir <= bus.bus_in;
        end
    end

    // Next-state and control decode; everything forced low while reset is asserted
    always_comb begin
        state_n     = state;
        ir_load     = 1'b0;
        bus.IMM     = '0;
        bus.imm_oe  = 1'b0;
        bus.Rin     = 2'b00;
        bus.Rout    = 2'b00;
        bus.ENW     = 1'b0;
        bus.ENR     = 1'b0;
        bus.Ain     = 1'b0;
        bus.Gin     = 1'b0;
        bus.Gout    = 1'b0;
        bus.ALUcont = 4'b0000;
        bus.Ext     = 1'b0;
        bus.IRin    = 1'b0;
        bus.done    = 1'b0;
        bus.illegal = 1'b0;
        bus.tstep   = state;
        if (!rst) begin
            unique case (state)
                T0: begin
                    bus.Ext  = 1'b1;
                    bus.IRin = 1'b1;
                    if (ext_ok) begin
                        ir_load = 1'b1;
                        state_n = T1;
                    end
                end
                T1: begin
                    if (is_illegal) begin
                        bus.illegal = 1'b1;
                        state_n     = T0;
                    end else if (is_load) begin
                        bus.Ext = 1'b1;
                        if (ext_ok) begin
                            bus.ENW  = 1'b1;
                            bus.Rin  = rx;
                            bus.done = 1'b1;
                            state_n  = T0;
                        end
                    end else if (is_copy) begin
                        bus.ENR  = 1'b1;
                        bus.Rout = ry;
                        bus.ENW  = 1'b1;
                        bus.Rin  = rx;
                        bus.done = 1'b1;
                        state_n  = T0;
                    end else begin
                        bus.ENR  = 1'b1;
                        bus.Rout = rx;
                        bus.Ain  = 1'b1;
                        state_n  = T2;
                    end
                end
                T2: begin
                    bus.Gin = 1'b1;
                    if (is_imm) begin
                        bus.imm_oe  = 1'b1;
                        bus.IMM     = imm_ext;
                        bus.ALUcont = (cls == CLS_SUBI) ? ALU_SUB : ALU_ADD;
                    end else begin
                        bus.ENR     = 1'b1;
                        bus.Rout    = ry;
                        bus.ALUcont = op;
                    end
                    state_n = T3;
                end
                T3: begin
                    bus.Gout = 1'b1;
                    bus.ENW  = 1'b1;
                    bus.Rin  = rx;
                    bus.done = 1'b1;
                    state_n  = T0;
                end
            endcase
        end
    end

    // is_alu is implied by the T1 fall-through; kept visible for the decode bundle
    logic unused_ok;
    assign unused_ok = is_alu;
endmodule

// File: tb/tb_bb_seq_controller.sv
// Directed bench for bb_seq_controller at DATA_W=10, zero- and sign-extended immediates.
module tb_bb_seq_controller;
    import bitblaster_pkg::*;

    typedef struct packed {
        logic       ext, irin, enr, enw, ain, gin, gout, imm_oe, done, illegal;
        logic [1:0] rin, rout;
        logic [3:0] alu;
        logic [1:0] tstep;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    bb_seq_controller_if #(.DATA_W(10)) bus0 ();
    bb_seq_controller_if #(.DATA_W(10)) bus1 ();

    bb_seq_controller #(.DATA_W(10), .IMM_SIGNED(1'b0), .EXT_HANDSHAKE(1'b1)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    bb_seq_controller #(.DATA_W(10), .IMM_SIGNED(1'b1), .EXT_HANDSHAKE(1'b1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    always #5 clk = ~clk;

    ctl_t obs;
    assign obs = '{ext: bus0.Ext, irin: bus0.IRin, enr: bus0.ENR, enw: bus0.ENW,
                   ain: bus0.Ain, gin: bus0.Gin, gout: bus0.Gout, imm_oe: bus0.imm_oe,
                   done: bus0.done, illegal: bus0.illegal, rin: bus0.Rin,
                   rout: bus0.Rout, alu: bus0.ALUcont, tstep: bus0.tstep};

    task automatic chk(input string tag, input ctl_t ex);
        tests++;
        assert (obs === ex) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, ex);
        end
    endtask

    task automatic chk_imm(input string tag, input logic [9:0] o, input logic [9:0] ex);
        tests++;
        assert (o === ex) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, ex);
        end
    endtask

    task automatic drive(input logic [9:0] b, input logic ev);
        bus0.bus_in = b; bus0.ext_valid = ev;
        bus1.bus_in = b; bus1.ext_valid = ev;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic ctl_t t0();
        ctl_t e = '0;
        e.ext = 1'b1; e.irin = 1'b1; e.tstep = 2'd0;
        return e;
    endfunction

    // Present an instruction in T0 with ext_valid high and advance into T1
    task automatic fetch(input string tag, input logic [9:0] instr);
        drive(instr, 1'b1);
        chk(tag, t0());
        cyc();
        drive(10'h000, 1'b0);
    endtask

    ctl_t e;

    initial begin
        drive(10'h000, 1'b0);
        cyc();
        chk("reset_all_zero", '0);
        chk_imm("reset_imm0", bus0.IMM, 10'h000);
        drive(10'h3FF, 1'b1);
        chk("reset_ignores_ev", '0);
        cyc();
        drive(10'h000, 1'b0);

        rst = 1'b0;
        drive(10'h000, 1'b0);
        chk("t0_after_release", t0());
        cyc();
        chk("t0_hold_no_valid", t0());

        // add R1,R2
        fetch("add_t0", 10'b00_01_10_0010);
        e = '0; e.enr = 1; e.rout = 2'b01; e.ain = 1; e.tstep = 2'd1;
        chk("add_t1", e);
        cyc();
        e = '0; e.enr = 1; e.rout = 2'b10; e.gin = 1; e.alu = 4'b0010; e.tstep = 2'd2;
        chk("add_t2", e);
        cyc();
        e = '0; e.gout = 1; e.enw = 1; e.rin = 2'b01; e.done = 1; e.tstep = 2'd3;
        chk("add_t3", e);
        cyc();

        // addi R3,#63
        fetch("addi_t0", 10'b10_11_111111);
        e = '0; e.enr = 1; e.rout = 2'b11; e.ain = 1; e.tstep = 2'd1;
        chk("addi_t1", e);
        cyc();
        e = '0; e.imm_oe = 1; e.gin = 1; e.alu = 4'b0010; e.tstep = 2'd2;
        chk("addi_t2", e);
        chk_imm("addi_imm_zext", bus0.IMM, 10'b0000111111);
        chk_imm("addi_imm_sext", bus1.IMM, 10'b1111111111);
        cyc();
        e = '0; e.gout = 1; e.enw = 1; e.rin = 2'b11; e.done = 1; e.tstep = 2'd3;
        chk("addi_t3", e);
        cyc();

        // subi R1,#31 (positive, so both extensions agree)
        fetch("subi_t0", 10'b11_01_011111);
        cyc();
        e = '0; e.imm_oe = 1; e.gin = 1; e.alu = 4'b0011; e.tstep = 2'd2;
        chk("subi_t2", e);
        chk_imm("subi_imm_sext_pos", bus1.IMM, 10'b0000011111);
        cyc();
        cyc();

        // asr R3,R0: top of the ALU opcode range
        fetch("asr_t0", 10'b00_11_00_1011);
        cyc();
        e = '0; e.enr = 1; e.rout = 2'b00; e.gin = 1; e.alu = 4'b1011; e.tstep = 2'd2;
        chk("asr_t2", e);
        cyc();
        e = '0; e.gout = 1; e.enw = 1; e.rin = 2'b11; e.done = 1; e.tstep = 2'd3;
        chk("asr_t3", e);
        cyc();

        // ld R2 with three stall cycles
        fetch("ld_t0", 10'b00_10_00_0000);
        e = '0; e.ext = 1; e.tstep = 2'd1;
        chk("ld_stall0", e);
        cyc();
        chk("ld_stall1", e);
        cyc();
        chk("ld_stall2", e);
        drive(10'h000, 1'b1);
        e = '0; e.ext = 1; e.enw = 1; e.rin = 2'b10; e.done = 1; e.tstep = 2'd1;
        chk("ld_retire", e);
        cyc();
        drive(10'h000, 1'b0);
        chk("ld_back_t0", t0());

        // Illegal encodings
        fetch("ill_cls01_t0", 10'b01_00_00_0000);
        e = '0; e.illegal = 1; e.tstep = 2'd1;
        chk("ill_cls01_t1", e);
        cyc();
        chk("ill_cls01_next", t0());
        fetch("ill_op1110_t0", 10'b00_00_00_1110);
        chk("ill_op1110_t1", e);
        cyc();
        chk("ill_op1110_next", t0());
        fetch("ill_op1100_t0", 10'b00_00_00_1100);
        chk("ill_op1100_t1", e);
        cyc();

        // cp R0,R3 then back-to-back fetch of sub R2,R1
        fetch("cp_t0", 10'b00_00_11_0001);
        e = '0; e.enr = 1; e.rout = 2'b11; e.enw = 1; e.rin = 2'b00; e.done = 1; e.tstep = 2'd1;
        chk("cp_t1", e);
        cyc();
        fetch("sub_t0_b2b", 10'b00_10_01_0011);
        e = '0; e.enr = 1; e.rout = 2'b10; e.ain = 1; e.tstep = 2'd1;
        chk("sub_t1", e);
        cyc();
        e = '0; e.enr = 1; e.rout = 2'b01; e.gin = 1; e.alu = 4'b0011; e.tstep = 2'd2;
        chk("sub_t2", e);

        // Reset during T2 aborts the instruction
        rst = 1'b1;
        #1;
        chk("abort_zero_now", '0);
        cyc();
        chk("abort_zero_held", '0);
        rst = 1'b0;
        #1;
        chk("abort_t0_release", t0());
        cyc();
        chk("abort_t0_stays", t0());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
